// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//
// Two-requester UART transmitter. Each requester offers one byte at a time on
// a valid/ready pair; a round-robin arbiter picks one requester while the line
// is idle, the byte is captured, and it is serialised as an 8N1 frame
// (start bit 0, data LSB first, stop bit 1). Each bit lasts DIV = CLK_F/BAUD
// clock cycles.
//
// Optional feature (compile-time macro UART_TX_PARITY_EN):
//   when defined, an even-parity bit (XOR of the data byte) is inserted
//   between data[7] and the stop bit, giving an 11-bit frame.
//
// Handshake: reqN_ready is combinational and is only ever raised in IDLE for
// the single requester that wins arbitration. A byte is transferred on the
// rising clock edge where reqN_valid and reqN_ready are both high. Requesters
// hold valid and data stable until they see ready; a valid that drops before
// that edge is simply never accepted.
//
// Ports:
//   clk         in   single clock, all logic on posedge
//   rst_n       in   asynchronous active-low reset
//   req0_valid  in   requester 0 offers a byte
//   req0_data   in   requester 0 byte [7:0]
//   req0_ready  out  requester 0 byte accepted this cycle
//   req1_valid  in   requester 1 offers a byte
//   req1_data   in   requester 1 byte [7:0]
//   req1_ready  out  requester 1 byte accepted this cycle
//   tx          out  serial line, idle high, registered
//   busy        out  frame in progress (FSM is in SEND)
//   grant_id    out  requester owning the current or last frame
//   bit_cnt     out  bit periods completed in the current frame [3:0]
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter int CLK_F = 25000000,
    parameter int BAUD  = 9600
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    output logic       tx,
    output logic       busy,
    output logic       grant_id,
    output logic [3:0] bit_cnt
);

    // Cycles per bit; values below 2 are not supported.
    localparam int DIV = CLK_F / BAUD;
    localparam int CW  = $clog2(DIV + 1);
    localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);

`ifdef UART_TX_PARITY_EN
    localparam logic [3:0] FRAME_LEN = 4'd11;
`else
    localparam logic [3:0] FRAME_LEN = 4'd10;
`endif

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t          state;
    state_t          state_next;

    logic [CW-1:0]   baud_cnt;
    logic [3:0]      bit_cnt_q;
    logic [7:0]      data_q;
    logic            tx_q;
    logic            grant_q;
    // Requester that wins the next contested grant (the one not granted last).
    logic            rr_prefer;

    logic            pick;
    logic            accept;
    logic            period_end;
    logic            last_bit;

    // Value driven on the line during bit period idx of the frame.
    function automatic logic frame_bit(input logic [3:0] idx, input logic [7:0] d);
        logic b;
        b = 1'b1;
        case (idx)
            4'd0: b = 1'b0;
            4'd1: b = d[0];
            4'd2: b = d[1];
            4'd3: b = d[2];
            4'd4: b = d[3];
            4'd5: b = d[4];
            4'd6: b = d[5];
            4'd7: b = d[6];
            4'd8: b = d[7];
`ifdef UART_TX_PARITY_EN
            4'd9: b = ^d;
`endif
            default: b = 1'b1;
        endcase
        return b;
    endfunction

    assign last_bit = (bit_cnt_q == FRAME_LEN - 4'd1);

    // -------------------------------------------------------------------------
    // FSM state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // Arbitration, handshake and next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        period_end = 1'b0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;

        // Contested: round-robin choice; otherwise whoever is valid.
        if (req0_valid && req1_valid) begin
            pick = rr_prefer;
        end else begin
            pick = req1_valid;
        end

        case (state)
            IDLE: begin
                // Ready is gated by rst_n so it drops the instant reset asserts.
                if (rst_n && (req0_valid || req1_valid)) begin
                    accept     = 1'b1;
                    req0_ready = ~pick;
                    req1_ready = pick;
                    state_next = SEND;
                end
            end
            SEND: begin
                if (baud_cnt == DIV_LAST) begin
                    period_end = 1'b1;
                    if (last_bit) begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath: capture, baud timing, bit counting and line driver
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            baud_cnt  <= '0;
            bit_cnt_q <= 4'd0;
            data_q    <= 8'h00;
            tx_q      <= 1'b1;
            grant_q   <= 1'b0;
            rr_prefer <= 1'b0;
        end else begin
            if (state == IDLE) begin
                if (accept) begin
                    data_q    <= pick ? req1_data : req0_data;
                    grant_q   <= pick;
                    rr_prefer <= ~pick;
                    baud_cnt  <= '0;
                    bit_cnt_q <= 4'd0;
                    // Start bit goes out on the cycle right after acceptance.
                    tx_q      <= 1'b0;
                end
            end else begin
                if (period_end) begin
                    baud_cnt <= '0;
                    if (bit_cnt_q < FRAME_LEN) begin
                        bit_cnt_q <= bit_cnt_q + 4'd1;
                    end
                    // After the stop bit the line simply stays high.
                    if (last_bit) begin
                        tx_q <= 1'b1;
                    end else begin
                        tx_q <= frame_bit(bit_cnt_q + 4'd1, data_q);
                    end
                end else begin
                    baud_cnt <= baud_cnt + CW'(1);
                end
            end
        end
    end

    assign tx       = tx_q;
    assign busy     = (state == SEND);
    assign grant_id = grant_q;
    assign bit_cnt  = bit_cnt_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arbiter
//
// Directed bench for uart_tx_arbiter. Two instances share clock and reset:
//   d_*  default parameters (DIV = 2604), used for the full-rate single byte
//   f_*  CLK_F=1000, BAUD=200 (DIV = 5), used for everything else
// Each scenario task drives stimulus and compares inline against values
// computed here from the frame format.
// -----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

    localparam int DIV_D = 2604;
    localparam int DIV_F = 5;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME = 11;
`else
    localparam int FRAME = 10;
`endif

    logic       clk;
    logic       rst_n;

    logic       d_req0_valid, d_req1_valid;
    logic [7:0] d_req0_data, d_req1_data;
    logic       d_req0_ready, d_req1_ready;
    logic       d_tx, d_busy, d_grant_id;
    logic [3:0] d_bit_cnt;

    logic       f_req0_valid, f_req1_valid;
    logic [7:0] f_req0_data, f_req1_data;
    logic       f_req0_ready, f_req1_ready;
    logic       f_tx, f_busy, f_grant_id;
    logic [3:0] f_bit_cnt;

    int vectors     = 0;
    int miscompares = 0;

    logic both_ready_seen = 1'b0;
    logic send_ready_seen = 1'b0;
    int   d_ready_cycles  = 0;

    uart_tx_arbiter dut_d (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(d_req0_valid), .req0_data(d_req0_data), .req0_ready(d_req0_ready),
        .req1_valid(d_req1_valid), .req1_data(d_req1_data), .req1_ready(d_req1_ready),
        .tx(d_tx), .busy(d_busy), .grant_id(d_grant_id), .bit_cnt(d_bit_cnt)
    );

    uart_tx_arbiter #(.CLK_F(1000), .BAUD(200)) dut_f (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(f_req0_valid), .req0_data(f_req0_data), .req0_ready(f_req0_ready),
        .req1_valid(f_req1_valid), .req1_data(f_req1_data), .req1_ready(f_req1_ready),
        .tx(f_tx), .busy(f_busy), .grant_id(f_grant_id), .bit_cnt(f_bit_cnt)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Handshake observers: sampled mid-cycle, inputs are stable there.
    always @(negedge clk) begin
        if (rst_n) begin
            if ((f_req0_ready && f_req1_ready) || (d_req0_ready && d_req1_ready))
                both_ready_seen = 1'b1;
            if ((f_busy && (f_req0_ready || f_req1_ready)) ||
                (d_busy && (d_req0_ready || d_req1_ready)))
                send_ready_seen = 1'b1;
            if (d_req0_ready)
                d_ready_cycles++;
        end
    end

    // Expected line bits, index = bit period. Unused high bits are 0.
    function automatic logic [10:0] exp_frame(input logic [7:0] d);
        logic [10:0] e;
        e = '0;
        e[0]   = 1'b0;
        e[8:1] = d;
`ifdef UART_TX_PARITY_EN
        e[9]   = ^d;
        e[10]  = 1'b1;
`else
        e[9]   = 1'b1;
`endif
        return e;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Waits for a handshake on the fast instance; returns one cycle after it
    // (first cycle of the frame), positioned 1 time unit after the edge.
    task automatic wait_accept(input int limit, output int who, output logic [7:0] data,
                               output int waited, output logic ok);
        ok = 1'b0; who = -1; waited = 0; data = 8'h00;
        while (!ok && waited < limit) begin
            #1;
            if (f_req0_valid && f_req0_ready) begin
                ok = 1'b1; who = 0; data = f_req0_data;
            end else if (f_req1_valid && f_req1_ready) begin
                ok = 1'b1; who = 1; data = f_req1_data;
            end
            @(posedge clk);
            #1;
            if (!ok) waited++;
        end
    endtask

    // Records a fast-instance frame starting at its first cycle. Ends on the
    // first cycle where busy is low.
    task automatic capture_frame(output logic [10:0] bits, output int busy_len,
                                 output int glitches, output int cnt_err);
        int   k;
        logic start;
        bits = '0; glitches = 0; cnt_err = 0; k = 0; start = 1'b1;
        while (f_busy && k < 200) begin
            if (k % DIV_F == 0) start = f_tx;
            else if (f_tx !== start) glitches++;
            if ((k % DIV_F == DIV_F / 2) && (k / DIV_F < 11)) bits[k / DIV_F] = f_tx;
            if (f_bit_cnt !== 4'(k / DIV_F)) cnt_err++;
            step();
            k++;
        end
        busy_len = k;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        d_req0_valid = 1'b0; d_req1_valid = 1'b0; d_req0_data = 8'h00; d_req1_data = 8'h00;
        f_req0_valid = 1'b1; f_req1_valid = 1'b1; f_req0_data = 8'hA5; f_req1_data = 8'h3C;
        step(); step();
        vectors++;
        if ({f_tx, f_busy, f_req0_ready, f_req1_ready, f_grant_id, f_bit_cnt} !== 9'b1_0_0_0_0_0000) begin
            miscompares++;
            $display("FAIL reset_fast: got tx/busy/r0/r1/gid/cnt=%b expected 100000000",
                     {f_tx, f_busy, f_req0_ready, f_req1_ready, f_grant_id, f_bit_cnt});
        end
        vectors++;
        if ({d_tx, d_busy, d_req0_ready, d_req1_ready, d_grant_id, d_bit_cnt} !== 9'b1_0_0_0_0_0000) begin
            miscompares++;
            $display("FAIL reset_default: got tx/busy/r0/r1/gid/cnt=%b expected 100000000",
                     {d_tx, d_busy, d_req0_ready, d_req1_ready, d_grant_id, d_bit_cnt});
        end
    endtask

    task automatic test_contention();
        int who, waited, blen, gl, ce;
        logic ok;
        logic [7:0] data;
        logic [10:0] bits;
        rst_n = 1'b1;
        wait_accept(10, who, data, waited, ok);
        f_req0_valid = 1'b0;
        vectors++;
        if (!ok || who != 0 || data !== 8'hA5 || f_grant_id !== 1'b0) begin
            miscompares++;
            $display("FAIL contention_first: got ok=%0b who=%0d data=%h gid=%b expected 1 0 a5 0",
                     ok, who, data, f_grant_id);
        end
        capture_frame(bits, blen, gl, ce);
        vectors++;
        if (bits !== exp_frame(8'hA5) || blen != FRAME * DIV_F || gl != 0 || ce != 0) begin
            miscompares++;
            $display("FAIL contention_frame0: bits=%b len=%0d gl=%0d ce=%0d expected %b %0d 0 0",
                     bits, blen, gl, ce, exp_frame(8'hA5), FRAME * DIV_F);
        end
        vectors++;
        if (f_tx !== 1'b1 || f_bit_cnt !== 4'(FRAME)) begin
            miscompares++;
            $display("FAIL idle_after_frame: tx=%b cnt=%0d expected 1 %0d", f_tx, f_bit_cnt, FRAME);
        end
        wait_accept(10, who, data, waited, ok);
        f_req1_valid = 1'b0;
        // Start gap = frame cycles + the one mandatory IDLE cycle.
        vectors++;
        if (!ok || who != 1 || data !== 8'h3C || f_grant_id !== 1'b1 ||
            blen + 1 + waited != FRAME * DIV_F + 1) begin
            miscompares++;
            $display("FAIL contention_second: ok=%0b who=%0d data=%h gid=%b gap=%0d expected 1 1 3c 1 %0d",
                     ok, who, data, f_grant_id, blen + 1 + waited, FRAME * DIV_F + 1);
        end
        capture_frame(bits, blen, gl, ce);
        vectors++;
        if (bits !== exp_frame(8'h3C) || blen != FRAME * DIV_F || gl != 0 || ce != 0) begin
            miscompares++;
            $display("FAIL contention_frame1: bits=%b len=%0d gl=%0d ce=%0d expected %b %0d 0 0",
                     bits, blen, gl, ce, exp_frame(8'h3C), FRAME * DIV_F);
        end
    endtask

    task automatic test_default_single();
        logic [10:0] e;
        int k;
        e = exp_frame(8'h55);
        d_req0_data = 8'h55;
        d_req0_valid = 1'b1;
        #1;
        vectors++;
        if (d_req0_ready !== 1'b1 || d_req1_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL default_ready: r0=%b r1=%b expected 1 0", d_req0_ready, d_req1_ready);
        end
        @(posedge clk);
        #1;
        d_req0_valid = 1'b0;
        k = 0;
        while (d_busy && k < 30000) begin
            if (k % DIV_D == 0 || k % DIV_D == DIV_D - 1) begin
                vectors++;
                if (d_tx !== e[k / DIV_D]) begin
                    miscompares++;
                    $display("FAIL default_bit: cycle %0d tx=%b expected %b", k, d_tx, e[k / DIV_D]);
                end
            end
            step();
            k++;
        end
        vectors++;
        if (k != FRAME * DIV_D || d_tx !== 1'b1 || d_bit_cnt !== 4'(FRAME) || d_grant_id !== 1'b0) begin
            miscompares++;
            $display("FAIL default_busy_len: len=%0d tx=%b cnt=%0d gid=%b expected %0d 1 %0d 0",
                     k, d_tx, d_bit_cnt, d_grant_id, FRAME * DIV_D, FRAME);
        end
        vectors++;
        if (d_ready_cycles != 1) begin
            miscompares++;
            $display("FAIL default_ready_cycles: got %0d expected 1", d_ready_cycles);
        end
    endtask

    task automatic test_fairness();
        int who, waited, blen, gl, ce;
        logic ok;
        logic [7:0] data;
        logic [10:0] bits;
        f_req0_data = 8'h11; f_req1_data = 8'h22;
        f_req0_valid = 1'b1; f_req1_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_accept(3 * FRAME * DIV_F, who, data, waited, ok);
            vectors++;
            if (!ok || who != (i % 2) || f_grant_id !== 1'((i % 2)) || waited != 0) begin
                miscompares++;
                $display("FAIL fairness_grant%0d: ok=%0b who=%0d gid=%b waited=%0d expected 1 %0d %0d 0",
                         i, ok, who, f_grant_id, waited, i % 2, i % 2);
            end
            if (i == 3) begin
                f_req0_valid = 1'b0; f_req1_valid = 1'b0;
            end
            capture_frame(bits, blen, gl, ce);
            vectors++;
            if (bits !== exp_frame((i % 2 == 0) ? 8'h11 : 8'h22) || blen != FRAME * DIV_F || gl != 0) begin
                miscompares++;
                $display("FAIL fairness_frame%0d: bits=%b len=%0d gl=%0d", i, bits, blen, gl);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        int who, waited, blen, gl, ce, k, bad;
        logic ok;
        logic [7:0] data;
        logic [10:0] bits;
        f_req1_data = 8'h96;
        f_req1_valid = 1'b1;
        wait_accept(10, who, data, waited, ok);
        f_req1_valid = 1'b0;
        k = 0;
        while (f_bit_cnt != 4'd4 && k < 200) begin
            step();
            k++;
        end
        vectors++;
        if (!ok || who != 1 || f_bit_cnt !== 4'd4 || f_busy !== 1'b1) begin
            miscompares++;
            $display("FAIL midreset_setup: ok=%0b who=%0d cnt=%0d busy=%b expected 1 1 4 1",
                     ok, who, f_bit_cnt, f_busy);
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({f_tx, f_busy, f_grant_id, f_bit_cnt} !== 7'b1_0_0_0000) begin
            miscompares++;
            $display("FAIL midreset_immediate: tx/busy/gid/cnt=%b expected 1000000",
                     {f_tx, f_busy, f_grant_id, f_bit_cnt});
        end
        step(); step();
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 3 * DIV_F; i++) begin
            if (f_tx !== 1'b1 || f_busy !== 1'b0) bad++;
            step();
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL midreset_no_resend: %0d active cycles expected 0", bad);
        end
        // Round-robin pointer is back to favouring requester 0.
        f_req0_data = 8'h3A; f_req1_data = 8'hC3;
        f_req0_valid = 1'b1; f_req1_valid = 1'b1;
        wait_accept(10, who, data, waited, ok);
        f_req0_valid = 1'b0; f_req1_valid = 1'b0;
        capture_frame(bits, blen, gl, ce);
        vectors++;
        if (!ok || who != 0 || bits !== exp_frame(8'h3A) || blen != FRAME * DIV_F || gl != 0 || ce != 0) begin
            miscompares++;
            $display("FAIL midreset_next_frame: ok=%0b who=%0d bits=%b len=%0d expected 1 0 %b %0d",
                     ok, who, bits, blen, exp_frame(8'h3A), FRAME * DIV_F);
        end
    endtask

    task automatic test_blip();
        int who, waited, blen, gl, ce, act;
        logic ok;
        logic [7:0] data;
        logic [10:0] bits;
        f_req0_data = 8'h0F;
        f_req0_valid = 1'b1;
        wait_accept(10, who, data, waited, ok);
        f_req0_valid = 1'b0;
        fork
            capture_frame(bits, blen, gl, ce);
            begin
                repeat (7) step();
                f_req0_data  = 8'hFF;
                f_req1_data  = 8'hEE;
                f_req1_valid = 1'b1;
                step();
                f_req1_valid = 1'b0;
            end
        join
        vectors++;
        if (!ok || bits !== exp_frame(8'h0F) || blen != FRAME * DIV_F || gl != 0) begin
            miscompares++;
            $display("FAIL blip_frame: bits=%b len=%0d gl=%0d expected %b %0d 0",
                     bits, blen, gl, exp_frame(8'h0F), FRAME * DIV_F);
        end
        act = 0;
        for (int i = 0; i < 3 * DIV_F; i++) begin
            if (f_busy !== 1'b0 || f_tx !== 1'b1 || f_req1_ready !== 1'b0) act++;
            step();
        end
        vectors++;
        if (act != 0) begin
            miscompares++;
            $display("FAIL blip_no_frame: %0d active cycles expected 0", act);
        end
    endtask

    task automatic test_pattern_07();
        int who, waited, blen, gl, ce;
        logic ok;
        logic [7:0] data;
        logic [10:0] bits;
        f_req1_data = 8'h07;
        f_req1_valid = 1'b1;
        wait_accept(10, who, data, waited, ok);
        f_req1_valid = 1'b0;
        capture_frame(bits, blen, gl, ce);
        vectors++;
        if (!ok || who != 1 || bits !== exp_frame(8'h07) || blen != FRAME * DIV_F ||
            f_bit_cnt !== 4'(FRAME)) begin
            miscompares++;
            $display("FAIL frame_07: ok=%0b who=%0d bits=%b len=%0d cnt=%0d expected 1 1 %b %0d %0d",
                     ok, who, bits, blen, f_bit_cnt, exp_frame(8'h07), FRAME * DIV_F, FRAME);
        end
`ifdef UART_TX_PARITY_EN
        vectors++;
        if (bits[9] !== 1'b1 || blen != 11 * DIV_F) begin
            miscompares++;
            $display("FAIL parity_07: parity=%b len=%0d expected 1 %0d", bits[9], blen, 11 * DIV_F);
        end
`endif
    endtask

    task automatic test_ready_rules();
        vectors++;
        if (both_ready_seen !== 1'b0 || send_ready_seen !== 1'b0) begin
            miscompares++;
            $display("FAIL ready_rules: both=%b in_send=%b expected 0 0", both_ready_seen, send_ready_seen);
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_contention();
        test_default_single();
        test_fairness();
        test_reset_mid_frame();
        test_blip();
        test_pattern_07();
        test_ready_rules();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
